// File: rtl/lstm_act_pkg.sv
// Shared constants for the LSTM activation blocks (Q6.6 fixed point).
package lstm_act_pkg;

    localparam int unsigned WIDTH     = 12;
    localparam int unsigned FRAC_BITS = 6;
    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned ID_W      = 2;

    localparam logic [11:0] ONE_Q66  = 12'h040;
    localparam logic [11:0] HALF_Q66 = 12'h020;
    localparam logic [11:0] SIX_Q66  = 12'h180;

endpackage

// File: rtl/sigmoid_share_arbiter_sigmoid.sv
// Combinational sigmoid in Q6.6: 0.25-step LUT over [0, 6], symmetric for
// negative inputs (1 - LUT), saturating to 1.0 / 0.0 beyond +/-6.0.
module sigmoid_share_arbiter_sigmoid #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned FRAC_BITS = 6
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);
    import lstm_act_pkg::*;

    logic             neg;
    logic [WIDTH-1:0] mag;
    logic [4:0]       idx;
    logic [WIDTH-1:0] lut;

    // Magnitude and LUT index; the most negative code negates to itself and
    // is caught by the saturation compare as a large magnitude.
    always_comb begin
        neg = x_i[WIDTH-1];
        mag = neg ? (~x_i + 1'b1) : x_i;
        idx = 5'(mag >> (FRAC_BITS - 2));
    end

    // round(64 * sigmoid(idx / 4)) for idx = 0..24
    always_comb begin
        lut = WIDTH'(ONE_Q66);
        case (idx)
            5'd0:  lut = WIDTH'(HALF_Q66);
            5'd1:  lut = WIDTH'(36);
            5'd2:  lut = WIDTH'(40);
            5'd3:  lut = WIDTH'(43);
            5'd4:  lut = WIDTH'(47);
            5'd5:  lut = WIDTH'(50);
            5'd6:  lut = WIDTH'(52);
            5'd7:  lut = WIDTH'(55);
            5'd8:  lut = WIDTH'(56);
            5'd9:  lut = WIDTH'(58);
            5'd10: lut = WIDTH'(59);
            5'd11: lut = WIDTH'(60);
            5'd12: lut = WIDTH'(61);
            5'd13: lut = WIDTH'(62);
            5'd14: lut = WIDTH'(62);
            5'd15: lut = WIDTH'(63);
            5'd16: lut = WIDTH'(63);
            5'd17: lut = WIDTH'(63);
            5'd18: lut = WIDTH'(63);
            5'd19: lut = WIDTH'(63);
            default: lut = WIDTH'(ONE_Q66);
        endcase
    end

    // Saturate outside +/-6.0, otherwise mirror the LUT for negative inputs.
    always_comb begin
        y_o = lut;
        if (mag > WIDTH'(SIX_Q66)) begin
            y_o = neg ? '0 : WIDTH'(ONE_Q66);
        end else if (neg) begin
            y_o = WIDTH'(ONE_Q66) - lut;
        end
    end

endmodule

// File: rtl/sigmoid_share_arbiter.sv
// Round-robin arbiter sharing one sigmoid unit among NUM_REQ gate requesters,
// with a single registered output stage under valid/ready flow control.
module sigmoid_share_arbiter #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned FRAC_BITS = 6,
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ID_W      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    input  logic                     resp_ready
);
    import lstm_act_pkg::*;

    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             can_accept;
    logic             issue;
    logic             found;
    logic [ID_W-1:0]  grant;
    logic [WIDTH-1:0] sig_in;
    logic [WIDTH-1:0] sig_out;
    int unsigned      cand;

    // Output stage can take a new result when empty or being popped; nothing
    // is accepted while reset is asserted.
    always_comb begin
        can_accept = rst_n && (!resp_valid_q || resp_ready);
        issue      = (|req_valid) && can_accept;
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                grant = cand[ID_W-1:0];
            end
        end
    end

    // Accept strobe only to the granted requester.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = issue && (grant == ID_W'(i));
        end
    end

    // Operand mux feeding the shared sigmoid.
    always_comb begin
        sig_in = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sig_in = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    sigmoid_share_arbiter_sigmoid #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_sigmoid (
        .x_i (sig_in),
        .y_o (sig_out)
    );

    // Next-state: load on issue, drop valid on a pop without refill, else hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        ptr_d        = ptr_q;
        if (issue) begin
            resp_valid_d = 1'b1;
            resp_data_d  = sig_out;
            resp_id_d    = grant;
            ptr_d        = grant;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers; reset points ptr at the last requester so 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            ptr_q        <= ID_W'(NUM_REQ - 1);
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;

endmodule

// File: doc/sigmoid_share_arbiter.md
SIGMOID_SHARE_ARBITER -- requirements
Module: sigmoid_share_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 12: data width of the Q6.6 fixed-point operand and result.
REQ-002 SHALL have parameter FRAC_BITS, default 6: number of fractional bits.
REQ-003 SHALL have parameter NUM_REQ, default 3: number of requesters (forget, input and output gates).
REQ-004 SHALL have parameter ID_W, default 2: width of the requester index, with ID_W >= clog2(NUM_REQ).
REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL provide port req_valid, input, NUM_REQ bits: per-requester valid, one bit per requester.
REQ-008 SHALL provide port req_data, input, NUM_REQ*WIDTH bits: per-requester operand; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL provide port req_ready, output, NUM_REQ bits: per-requester accept strobe.
REQ-010 SHALL provide port resp_valid, output, 1 bit: result valid.
REQ-011 SHALL provide port resp_data, output, WIDTH bits: sigmoid result in Q6.6.
REQ-012 SHALL provide port resp_id, output, ID_W bits: index of the requester that owns the result.
REQ-013 SHALL provide port resp_ready, input, 1 bit: downstream accept.

Function
REQ-014 SHALL share one combinational sigmoid unit among NUM_REQ requesters, using valid/ready handshakes on both sides.
REQ-015 SHALL define can_accept = !resp_valid || resp_ready.
REQ-016 SHALL select the grant g combinationally by round-robin: search from ptr+1 (mod NUM_REQ) upward and pick the first index whose req_valid is high.
REQ-017 SHALL drive req_ready[i] high only when i == g, req_valid[g] is high and can_accept is high; at most one req_ready bit is high per cycle.
REQ-018 SHALL define issue = |req_valid && can_accept; a transfer on requester i occurs when req_valid[i] && req_ready[i].
REQ-019 On issue, SHALL at the next edge load resp_data <= sigmoid(req_data[g]), resp_id <= g, resp_valid <= 1 and ptr <= g.
REQ-020 SHALL have a latency of exactly 1 cycle from transfer to resp_valid and a throughput of 1 result per cycle when resp_ready stays high.
REQ-021 When resp_valid && resp_ready && !issue, SHALL clear resp_valid at the next edge; resp_data and resp_id keep their values.
REQ-022 While resp_valid && !resp_ready, SHALL hold resp_data and resp_id stable and keep all req_ready bits low.
REQ-023 On a simultaneous downstream pop and new issue in the same cycle, SHALL keep resp_valid high and load the new result with no bubble.
REQ-024 SHALL leave ptr unchanged when there is no issue; ptr wraps from NUM_REQ-1 to 0.
REQ-025 SHALL make the sigmoid result bit-exact with the team's sigmoid block: input above 6.0 gives 12'h040; input in [0,6] gives the LUT value; negative input uses 1 - LUT, with saturation as in that block.
REQ-026 SHALL ignore req_data of requesters that are not granted; a requester dropping valid before a transfer is legal.

Reset
REQ-027 On rst_n low, SHALL immediately and asynchronously set resp_valid=0, resp_data=0, resp_id=0 and ptr=NUM_REQ-1, so that requester 0 has first priority.
REQ-028 Reset mid-operation SHALL discard any held result without emitting it; req_ready SHALL be 0 while rst_n is low.
REQ-029 Operation SHALL resume on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package lstm_act_pkg SHALL hold WIDTH, FRAC_BITS, the constants ONE_Q66=12'h040, HALF_Q66=12'h020 and SIX_Q66=12'h180, NUM_REQ and ID_W.
REQ-031 SHALL instantiate exactly one sub-module, the existing sigmoid, with its input fed by the granted operand mux; the round-robin logic and output register SHALL be written inline.
REQ-032 SHALL contain no other storage besides resp_valid, resp_data, resp_id and ptr.

Verification
REQ-033 Bench SHALL drive requester 0 alone with data 12'h000 and resp_ready=1 -> req_ready=3'b001 in the same cycle; next cycle resp_valid=1, resp_data=12'h020, resp_id=0.
REQ-034 Bench SHALL hold all three requesters valid with resp_ready=1 from reset -> grant order 0,1,2,0,1,2 with one resp_valid per cycle and no gaps.
REQ-035 Bench SHALL assert requester 1 with 12'h1C0 (7.0) -> resp_data=12'h040, resp_id=1.
REQ-036 Bench SHALL hold resp_ready=0 for 3 cycles while resp_valid=1 -> req_ready=0 and resp_data/resp_id unchanged; on resp_ready=1, the pop and next issue happen in the same cycle.
REQ-037 Bench SHALL assert rst_n low while resp_valid=1 and requesters are active -> resp_valid drops with no clock edge; after release, requester 0 is granted first.
REQ-038 Bench SHALL run a random sweep of operands with a scoreboard -> every result equals the standalone sigmoid of that operand, and no requester waits more than NUM_REQ grants.
